crc_mem_scanner: RTL and testbench
==================================

// Module: crc_mem_scanner
// PURPOSE
//  Avalon-MM read master that sits directly in front of the 4096x32 on-chip CRC memory (single-port, 1-cycle read latency).
//  On start it streams word_count words beginning at base_addr, one address per cycle.
//  It computes the CRC-32 (IEEE 802.3) over those words and reports the result to the Nios-side control logic.
//  Under CRC_WRITEBACK_EN it also stores the result back into the memory.
// PARAMETERS
//  ADDR_W     12          memory word-address width; address wraps modulo 2**ADDR_W
//  CNT_W      13          word_count width; covers 0..4096
//  CRC_INIT   32'hFFFFFFFF  CRC register seed
//  CRC_XOROUT 32'hFFFFFFFF  final XOR applied to the result
// PORTS
//  clk             in   1       system clock; single clock domain
//  reset           in   1       synchronous, active-high
//  start           in   1       1-cycle pulse; accepted only in IDLE
//  base_addr       in   ADDR_W  first word address
//  word_count      in   CNT_W   number of words to scan
//  busy            out  1       high from the cycle after an accepted start until done
//  done            out  1       1-cycle pulse when crc_out becomes valid
//  crc_out         out  32      final CRC; held until the next accepted start
//  avm_address     out  ADDR_W  memory address
//  avm_chipselect  out  1       memory select
//  avm_write       out  1       write strobe; 0 unless write-back is active
//  avm_byteenable  out  4       always 4'hF
//  avm_clken       out  1       always 1
//  avm_writedata   out  32      write-back data
//  avm_readdata    in   32      valid the cycle after its address was presented
// BEHAVIOUR
//  Reset values: busy=0, done=0, crc_out=0, avm_chipselect=0, avm_write=0, avm_address=0, state=IDLE.
//  Reset mid-scan aborts at once. No write is issued. crc_out reads 0.
//  FSM states: IDLE, READ, DRAIN, [WB], FIN.
//   - IDLE->READ on start with word_count!=0. Latch base_addr and word_count. crc_reg<=CRC_INIT.
//   - IDLE->FIN on start with word_count==0. crc_out = CRC_INIT^CRC_XOROUT = 0.
//   - READ: assert chipselect. Present addr, addr+1, ... one per cycle. Leave after the last address is issued.
//   - DRAIN: fold the last readdata. chipselect=0.
//   - Then go to WB if the macro is defined, otherwise go to FIN.
//   - FIN: crc_out<=crc_reg^CRC_XOROUT, done=1 for 1 cycle, busy=0, return to IDLE.
//  Pipelining: readdata for the address issued in cycle t is folded into crc_reg in cycle t+1.
//   A data_valid flag, delayed one cycle from chipselect&~write, gates the fold.
//  Byte order: bytes are processed [7:0], [15:8], [23:16], [31:24] in that order.
//   Reflected polynomial 32'hEDB88320, LSB first. All 32 bits are folded in one cycle.
//  Latency: start accepted in cycle 0 -> done in cycle N+3, where N=word_count. Add 1 cycle with CRC_WRITEBACK_EN.
//  Address wraps: base 4094, N=4 reads 4094, 4095, 0, 1.
//  start while busy is ignored. Inputs are sampled only on an accepted start.
//  avm_write is never asserted while avm_chipselect is low.
// CONFIGURATION
//  CRC_WRITEBACK_EN defined:
//   - WB state, 1 cycle: chipselect=1, write=1, address=base_addr+N (mod 4096).
//   - writedata = final CRC.
//   - done occurs in the following cycle.
//  CRC_WRITEBACK_EN undefined:
//   - WB state absent. avm_write is tied 0. avm_writedata is tied 0.
// STRUCTURE
//  Package crc_mem_pkg:
//   - CRC_POLY_REFL
//   - CRC_INIT / CRC_XOROUT defaults
//   - state encoding constants
//   - ADDR_W default
//  Sub-module crc32_word_update: combinational; inputs crc_in[31:0] and data[31:0], output crc_next.
//  The FSM, address counter, remaining-word counter and valid pipeline live in crc_mem_scanner.
// TESTING
//  1. base=0, N=1, mem[0]=32'h00000000 -> crc_out=32'h2144DF1C; done in cycle 4.
//  2. base=0, N=1, mem[0]=32'h34333231 ("1234") -> crc_out=32'h9BE3E0A3.
//  3. base=4094, N=4 -> addresses 4094, 4095, 0, 1 in that order; CRC matches the software model.
//  4. N=0 -> done 1 cycle after start; crc_out=0; chipselect never asserted.
//  5. Reset asserted mid-READ of N=100 -> next cycle busy=0, chipselect=0, crc_out=0; no done pulse.
//  6. start pulsed while busy -> ignored.
//     With CRC_WRITEBACK_EN: N=2, base=10 -> single write to addr 12 with data = crc_out.

Source files
------------

// File: rtl/crc_mem_pkg.sv
// Shared constants, state encoding and the bitwise CRC step used by the CRC memory scanner.
package crc_mem_pkg;

  localparam int          ADDR_W_DEF     = 12;
  localparam int          CNT_W_DEF      = 13;
  localparam logic [31:0] CRC_POLY_REFL  = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT_DEF   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOROUT_DEF = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WB    = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // One LSB-first shift of the reflected CRC-32 register.
  function automatic logic [31:0] crc32_shift_bit(input logic [31:0] c);
    if (c[0]) begin
      crc32_shift_bit = (c >> 1) ^ CRC_POLY_REFL;
    end else begin
      crc32_shift_bit = c >> 1;
    end
  endfunction

endpackage

// File: rtl/crc_mem_scanner_if.sv
// Control and Avalon-MM bus bundle between the scanner, its controller and the CRC memory.
interface crc_mem_scanner_if
  import crc_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
  logic              done;
  logic [31:0]       crc_out;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic              avm_clken;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;

  modport master (
    input  start, base_addr, word_count, avm_readdata,
    output busy, done, crc_out,
    output avm_address, avm_chipselect, avm_write, avm_byteenable, avm_clken, avm_writedata
  );

  modport slave (
    output start, base_addr, word_count, avm_readdata,
    input  busy, done, crc_out,
    input  avm_address, avm_chipselect, avm_write, avm_byteenable, avm_clken, avm_writedata
  );

endinterface

// File: rtl/crc32_word_update.sv
// Folds one 32-bit word into a reflected CRC-32 register in a single combinational step.
module crc32_word_update
  import crc_mem_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_next
);

  // Byte 0 LSB first through byte 3 MSB is exactly word bit 0 upward, so the whole word xors in at once.
  always_comb begin
    crc_next = crc_in ^ data;
    for (int i = 0; i < 32; i++) begin
      crc_next = crc32_shift_bit(crc_next);
    end
  end

endmodule

// File: rtl/crc_mem_scanner.sv
// Avalon-MM read master computing CRC-32 over a block of the CRC memory.
// Optional result write-back to base_addr+word_count is enabled by defining CRC_WRITEBACK_EN.
module crc_mem_scanner
  import crc_mem_pkg::*;
#(
  parameter int          ADDR_W     = ADDR_W_DEF,
  parameter int          CNT_W      = CNT_W_DEF,
  parameter logic [31:0] CRC_INIT   = CRC_INIT_DEF,
  parameter logic [31:0] CRC_XOROUT = CRC_XOROUT_DEF
) (
  input logic               clk,
  input logic               reset,
  crc_mem_scanner_if.master bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [31:0]       crc_q, crc_d;
  logic              dv_q;
  logic [31:0]       crc_fold_s;
  logic              accept_s;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       crc_out_q, crc_out_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cs_q, cs_d;

  assign accept_s = (state_q == ST_IDLE) && bus.start;

  crc32_word_update u_crc (
    .crc_in   (crc_q),
    .data     (bus.avm_readdata),
    .crc_next (crc_fold_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.word_count != {CNT_W{1'b0}}) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rem_q == {CNT_W{1'b0}}) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_READ;
        end
      end
`ifdef CRC_WRITEBACK_EN
      ST_DRAIN: state_d = ST_WB;
`else
      ST_DRAIN: state_d = ST_FIN;
`endif
      ST_WB:    state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Remaining-address counter and CRC accumulator; readdata lands one cycle after its address
  always_comb begin
    rem_d = rem_q;
    crc_d = crc_q;
    if (accept_s) begin
      rem_d = bus.word_count - CNT_W'(1);
      crc_d = CRC_INIT;
    end else if (dv_q) begin
      crc_d = crc_fold_s;
      if (state_q == ST_READ && rem_q != {CNT_W{1'b0}}) begin
        rem_d = rem_q - CNT_W'(1);
      end else begin
        rem_d = rem_q;
      end
    end else if (state_q == ST_READ && rem_q != {CNT_W{1'b0}}) begin
      rem_d = rem_q - CNT_W'(1);
    end else begin
      rem_d = rem_q;
    end
  end

  // Next values of the registered outputs
  always_comb begin
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_q == ST_FIN);
    cs_d      = (state_d == ST_READ) || (state_d == ST_WB);
    crc_out_d = crc_out_q;
    addr_d    = addr_q;
    if (state_q == ST_FIN) begin
      crc_out_d = crc_q ^ CRC_XOROUT;
    end else begin
      crc_out_d = crc_out_q;
    end
    if (accept_s) begin
      addr_d = bus.base_addr;
    end else if ((state_q == ST_READ && state_d == ST_READ) || state_d == ST_WB) begin
      addr_d = addr_q + ADDR_W'(1);
    end else begin
      addr_d = addr_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= {CNT_W{1'b0}};
      crc_q <= 32'h0000_0000;
      dv_q  <= 1'b0;
    end else begin
      rem_q <= rem_d;
      crc_q <= crc_d;
      dv_q  <= cs_q && !bus.avm_write;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      crc_out_q <= 32'h0000_0000;
      addr_q    <= {ADDR_W{1'b0}};
      cs_q      <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      crc_out_q <= crc_out_d;
      addr_q    <= addr_d;
      cs_q      <= cs_d;
    end
  end

`ifdef CRC_WRITEBACK_EN
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;

  // Write-back strobe and data; the final CRC is taken from the DRAIN fold as it is produced
  always_comb begin
    wr_d = (state_d == ST_WB);
    if (state_d == ST_WB) begin
      wdata_d = crc_d ^ CRC_XOROUT;
    end else begin
      wdata_d = wdata_q;
    end
  end

  // Write-back registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      wdata_q <= 32'h0000_0000;
    end else begin
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.avm_write     = wr_q;
  assign bus.avm_writedata = wdata_q;
`else
  assign bus.avm_write     = 1'b0;
  assign bus.avm_writedata = 32'h0000_0000;
`endif

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.crc_out        = crc_out_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_byteenable = 4'hF;
  assign bus.avm_clken      = 1'b1;

endmodule

// File: tb/tb_crc_mem_scanner.sv
// Scoreboard bench for crc_mem_scanner: byte-wise CRC reference model, memory model and output monitor.
`timescale 1ns/1ps
module tb_crc_mem_scanner;

  localparam int AW    = 12;
  localparam int CW    = 13;
  localparam int DEPTH = 4096;
`ifdef CRC_WRITEBACK_EN
  localparam int WB = 1;
`else
  localparam int WB = 0;
`endif

  typedef struct packed {
    logic [31:0] crc;
    logic [31:0] due;
  } exp_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wb_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          tb_wr;
  logic [AW-1:0] tb_addr;
  logic [31:0]   tb_data;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   cyc = 32'd0;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  wb_t           wb_q[$];

  always #5 clk = ~clk;

  crc_mem_scanner_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  crc_mem_scanner #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Single-port memory with 1-cycle read latency; the bench preloads it through tb_wr
  always @(posedge clk) begin
    if (tb_wr) begin
      mem[tb_addr] <= tb_data;
    end else if (bus.avm_chipselect && bus.avm_clken) begin
      if (bus.avm_write) mem[bus.avm_address] <= bus.avm_writedata;
      else               bus.avm_readdata     <= mem[bus.avm_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // CRC-32 over the bytes of mem[base..base+n-1] (wrapping), low byte of each word first
  function automatic logic [31:0] ref_crc(input int base, input int n);
    logic [31:0] c;
    logic [31:0] w;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      w = mem[AW'(base + i)];
      for (int b = 0; b < 4; b++) begin
        c = c ^ {24'h0, w[8*b +: 8]};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return c ^ 32'hFFFF_FFFF;
  endfunction

  // Monitor: reads, writes and done pulses are matched against the queued expectations
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.avm_chipselect && !bus.avm_write) begin
        if (addr_q.size() == 0) check("unexpected_read_addr", 32'(bus.avm_address), 32'hFFFF_FFFF);
        else                    check("read_addr", 32'(bus.avm_address), 32'(addr_q.pop_front()));
      end
      if (bus.avm_write) begin
        wb_t w;
        check("write_needs_cs", 32'(bus.avm_chipselect), 32'd1);
        if (wb_q.size() == 0) begin
          check("unexpected_write", 32'(bus.avm_address), 32'hFFFF_FFFF);
        end else begin
          w = wb_q.pop_front();
          check("wb_addr", 32'(bus.avm_address), 32'(w.addr));
          check("wb_data", bus.avm_writedata, w.data);
        end
      end
      if (bus.done) begin
        exp_t e;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("crc_out", bus.crc_out, e.crc);
          check("done_cycle", cyc, e.due);
          check("busy_at_done", 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  task automatic mem_wr(input int a, input logic [31:0] d);
    tb_wr = 1'b1; tb_addr = AW'(a); tb_data = d;
    @(posedge clk); #1;
    tb_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((exp_q.size() != 0) && (b < 6000)) begin
      @(posedge clk); #1;
      b++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete(); addr_q.delete(); wb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Issue one accepted start; expectations are queued before the accepting edge
  task automatic scan(input int base, input int n, input logic use_k, input logic [31:0] k);
    exp_t e;
    wait_idle();
    e.crc = use_k ? k : ref_crc(base, n);
    e.due = cyc + ((n == 0) ? 32'd2 : 32'(n + 3 + WB));
    for (int i = 0; i < n; i++) addr_q.push_back(AW'(base + i));
    if (WB == 1 && n != 0) wb_q.push_back({AW'(base + n), e.crc});
    exp_q.push_back(e);
    bus.start = 1'b1; bus.base_addr = AW'(base); bus.word_count = CW'(n);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.base_addr = AW'($urandom); bus.word_count = CW'($urandom);
  endtask

  initial begin
    reset = 1'b1; tb_wr = 1'b0; tb_addr = '0; tb_data = 32'h0;
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0;
    for (int i = 0; i < DEPTH; i++) mem_wr(i, $urandom);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_crc_out", bus.crc_out, 32'd0);
    check("rst_cs", 32'(bus.avm_chipselect), 32'd0);
    check("rst_write", 32'(bus.avm_write), 32'd0);
    check("rst_addr", 32'(bus.avm_address), 32'd0);
    check("byteenable", 32'(bus.avm_byteenable), 32'hF);
    check("clken", 32'(bus.avm_clken), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    mem_wr(0, 32'h0000_0000);
    scan(0, 1, 1'b1, 32'h2144_DF1C);
    wait_idle();
    mem_wr(0, 32'h3433_3231);
    scan(0, 1, 1'b1, 32'h9BE3_E0A3);
    scan(4094, 4, 1'b0, 32'h0);
    scan(0, 0, 1'b0, 32'h0);
    scan(10, 2, 1'b0, 32'h0);
    scan(4090, 10, 1'b0, 32'h0);

    // A start while busy must not disturb the scan in flight
    scan(int'($urandom_range(0, 4095)), 20, 1'b0, 32'h0);
    repeat (5) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.base_addr = AW'(7); bus.word_count = CW'(3);
    @(posedge clk); #1;
    bus.start = 1'b0;

    for (int t = 0; t < 16; t++) begin
      int n;
      n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
      scan(int'($urandom_range(0, 4095)), n, 1'b0, 32'h0);
    end

    // Reset in the middle of a long scan aborts it without a done pulse
    scan(int'($urandom_range(0, 4095)), 100, 1'b0, 32'h0);
    repeat (30) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); addr_q.delete(); wb_q.delete();
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_cs", 32'(bus.avm_chipselect), 32'd0);
    check("abort_crc_out", bus.crc_out, 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (120) begin @(posedge clk); #1; end

    scan(100, 3, 1'b0, 32'h0);
    wait_idle();
    check("addr_queue_empty", 32'(addr_q.size()), 32'd0);
    check("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
